fp_result_serializer: RTL and testbench
=======================================

Name: fp_result_serializer

Overview:
- Output-side counterpart to the FIFO-to-operand packer.
- Accepts 32-bit results from the FP arithmetic pipeline on a single-cycle valid strobe. The pipeline cannot be stalled.
- Buffers the results in a small queue, then serializes each one into bytes. Bytes are pushed into the USB TX FIFO, honouring the FIFO_full backpressure.
- Sits between the FP unit's delayed valid and the FIFO write port, inside the USB controller.

Parameters:
- WORD_BYTES, 4: bytes per result word. Data width = 8*WORD_BYTES.
- QUEUE_DEPTH, 4: result queue entries. Must be a power of 2 and ≥2.

Ports:
- clk_pll  in  1  system clock; all state updates on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  8*WORD_BYTES  result word from the FP unit.
- data_valid  in  1  one-cycle strobe; data is captured on this edge.
- FIFO_full  in  1  TX FIFO full. A push is not allowed while this is high.
- FIFO_input_data  out  8  byte to the TX FIFO.
- FIFO_push_data  out  1  push strobe; one byte is accepted per high cycle.
- busy  out  1  high while the queue is non-empty or a word is in flight.
- overflow  out  1  sticky; high once any result has been dropped.

Behaviour:
- Clock and reset: one clock (clk_pll). Reset is asynchronous, active-low (reset_n).
- Reset values:
  - state = IDLE; queue pointers and count = 0; shift register = 0; byte counter = 0.
  - FIFO_input_data = 0, FIFO_push_data = 0, busy = 0, overflow = 0.
- Queue:
  - Circular buffer of QUEUE_DEPTH words. Count width is clog2(QUEUE_DEPTH)+1.
  - Write: data_valid && (count<QUEUE_DEPTH || pop this cycle). A write at full is accepted when a pop happens on the same edge.
  - Drop: data_valid && count==QUEUE_DEPTH && no pop. The word is discarded and overflow is set to 1. overflow clears only on reset.
  - Simultaneous write and pop leaves count unchanged.
- State machine (2 states):
  - IDLE: if count>0, load the head word into the shift register, pop it, set the byte counter to 0, and go to SEND. Otherwise stay in IDLE.
  - SEND: FIFO_push_data = (state==SEND) && !FIFO_full. This is combinational from registered state and FIFO_full.
  - SEND, on a push edge: shift the register right by 8 and increment the byte counter.
  - SEND, last byte pushed (counter==WORD_BYTES-1) and count>0: load and pop the next word on the same edge and stay in SEND. There are no idle cycles between words.
  - SEND, last byte pushed and count==0: return to IDLE.
  - SEND with FIFO_full high: hold all SEND state; no push.
- Data path:
  - FIFO_input_data = shift_reg[7:0].
  - Byte order is least-significant first: byte k = data[8k+7:8k].
- Latency: data_valid in cycle 0, with an empty queue, in IDLE, and FIFO not full, gives pushes in cycles 2..(1+WORD_BYTES).
- Throughput: sustained acceptance is one word per WORD_BYTES cycles. Faster bursts are absorbed up to the queue depth.
- Busy: busy = (state!=IDLE) || (count!=0). It is combinational.
- Reset mid-word: the partial word and all queued words are discarded. FIFO_push_data drops immediately because it is derived from async-reset state. No partial word is resumed after reset.
- FIFO_full toggling: may change any cycle. Only cycles with FIFO_full low and state SEND push. A byte is never pushed twice or skipped.

Test Plan:
- Single word: data=0xAABBCCDD, data_valid in cycle 0, FIFO_full=0 → pushes DD, CC, BB, AA in cycles 2-5. Then IDLE, busy=0 from cycle 6, overflow=0.
- Backpressure: as above, but FIFO_full=1 in cycles 3-5 → push in cycle 2 (DD), none in 3-5, then CC, BB, AA in cycles 6-8. There are exactly 4 pushes.
- Back-to-back: data_valid in cycles 0-4 with words 0x0..0x4 → 20 bytes in order, continuous pushes in cycles 2-21, overflow=0.
- Overflow: data_valid in cycles 0-6, QUEUE_DEPTH=4, FIFO_full=0 →
  - words 0-5 are serialized (24 bytes);
  - word 6 is dropped;
  - overflow=1 from cycle 7 and stays high until reset.
- Reset mid-word: reset_n low in cycle 3 of the single-word case → FIFO_push_data=0 at once, overflow=0, busy=0. After reset release with no new data_valid, no pushes occur.
- Full-edge accept: queue full, with data_valid on the same edge as the last-byte pop → the word is accepted, count stays at 4, overflow stays 0.

Source files
------------

// File: rtl/fp_result_serializer_if.sv
// Result-word input and TX FIFO byte output of the FP result serializer.
// The master side feeds words and FIFO status; the slave side is the serializer.
interface fp_result_serializer_if #(
    parameter int unsigned WORD_BYTES = 4
);
    logic [8*WORD_BYTES-1:0] data;
    logic                    data_valid;
    logic                    FIFO_full;
    logic [7:0]              FIFO_input_data;
    logic                    FIFO_push_data;
    logic                    busy;
    logic                    overflow;

    modport master (
        output data, data_valid, FIFO_full,
        input  FIFO_input_data, FIFO_push_data, busy, overflow
    );

    modport slave (
        input  data, data_valid, FIFO_full,
        output FIFO_input_data, FIFO_push_data, busy, overflow
    );
endinterface

// File: rtl/fp_result_serializer.sv
// Queues non-stallable FP results and serializes each word LSB-first into
// the USB TX FIFO, honouring FIFO_full backpressure.
module fp_result_serializer #(
    parameter int unsigned WORD_BYTES  = 4,
    parameter int unsigned QUEUE_DEPTH = 4
) (
    input  logic                  clk_pll,
    input  logic                  reset_n,
    fp_result_serializer_if.slave bus
);
    localparam int unsigned DATA_W = 8 * WORD_BYTES;
    localparam int unsigned PTR_W  = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W  = $clog2(QUEUE_DEPTH) + 1;
    localparam int unsigned BCNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;

    localparam logic [CNT_W-1:0]  FULL_CNT  = CNT_W'(QUEUE_DEPTH);
    localparam logic [BCNT_W-1:0] LAST_BYTE = BCNT_W'(WORD_BYTES - 1);

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t              state_q;
    state_t              state_d;
    logic [DATA_W-1:0]   mem [QUEUE_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q;
    logic [PTR_W-1:0]    rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic [DATA_W-1:0]   shift_q;
    logic [BCNT_W-1:0]   byte_cnt_q;
    logic                overflow_q;

    logic                push_c;
    logic                pop_c;
    logic                wr_c;
    logic                drop_c;

    assign push_c = (state_q == SEND) && !bus.FIFO_full;

    // Next state and pop decision; a pop on the last byte keeps words gapless.
    always_comb begin
        state_d = state_q;
        pop_c   = 1'b0;
        case (state_q)
            IDLE: begin
                if (count_q != '0) begin
                    pop_c   = 1'b1;
                    state_d = SEND;
                end
            end
            SEND: begin
                if (push_c && (byte_cnt_q == LAST_BYTE)) begin
                    if (count_q != '0) begin
                        pop_c = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // A word arriving at full is still taken if the head leaves on the same edge.
    assign wr_c   = bus.data_valid && ((count_q != FULL_CNT) || pop_c);
    assign drop_c = bus.data_valid && (count_q == FULL_CNT) && !pop_c;

    always_ff @(posedge clk_pll or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_pll) begin
        if (wr_c) begin
            mem[wr_ptr_q] <= bus.data;
        end
    end

    always_ff @(posedge clk_pll or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            shift_q    <= '0;
            byte_cnt_q <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (wr_c) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop_c) begin
                rd_ptr_q   <= rd_ptr_q + PTR_W'(1);
                shift_q    <= mem[rd_ptr_q];
                byte_cnt_q <= '0;
            end else if (push_c) begin
                shift_q    <= shift_q >> 8;
                byte_cnt_q <= byte_cnt_q + BCNT_W'(1);
            end
            case ({wr_c, pop_c})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
            if (drop_c) begin
                overflow_q <= 1'b1;
            end
        end
    end

    assign bus.FIFO_input_data = shift_q[7:0];
    assign bus.FIFO_push_data  = push_c;
    assign bus.busy            = (state_q != IDLE) || (count_q != '0);
    assign bus.overflow        = overflow_q;
endmodule

// File: tb/tb_fp_result_serializer.sv
// Scoreboard bench for fp_result_serializer: expected bytes are queued as
// words are driven and compared as the DUT pushes them into the TX FIFO.
module tb_fp_result_serializer;
    localparam int unsigned WORD_BYTES  = 4;
    localparam int unsigned QUEUE_DEPTH = 4;

    logic clk_pll = 1'b0;
    logic reset_n = 1'b0;

    fp_result_serializer_if #(.WORD_BYTES(WORD_BYTES)) bus ();

    fp_result_serializer #(
        .WORD_BYTES (WORD_BYTES),
        .QUEUE_DEPTH(QUEUE_DEPTH)
    ) dut (
        .clk_pll(clk_pll),
        .reset_n(reset_n),
        .bus    (bus.slave)
    );

    always #5 clk_pll = ~clk_pll;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          n_push   = 0;
    logic [7:0]  sb [$];
    logic [31:0] words [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Every pushed byte must match the oldest outstanding expected byte.
    always @(negedge clk_pll) begin
        if (reset_n && bus.FIFO_push_data === 1'b1) begin
            n_push++;
            if (sb.size() == 0) begin
                check("unexpected_push", 32'(bus.FIFO_input_data), 32'hFFFF_FFFF);
            end else begin
                check("byte", 32'(bus.FIFO_input_data), 32'(sb.pop_front()));
            end
        end
    end

    // Per cycle c: drive valid/full from the masks, expect push and overflow per masks.
    task automatic run_seq(input string name, input int ncyc,
                           input logic [31:0] vmask, input logic [31:0] dmask,
                           input logic [31:0] fmask, input logic [31:0] pmask,
                           input logic [31:0] omask);
        logic [31:0] w;
        for (int c = 0; c < ncyc; c++) begin
            bus.data_valid = vmask[c];
            bus.FIFO_full  = fmask[c];
            if (vmask[c]) begin
                w = (words.size() != 0) ? words.pop_front() : $urandom;
                bus.data = w;
                if (!dmask[c]) begin
                    for (int k = 0; k < int'(WORD_BYTES); k++) begin
                        sb.push_back(8'(w >> (8 * k)));
                    end
                end
            end
            @(negedge clk_pll);
            check($sformatf("%s_push_c%0d", name, c), 32'(bus.FIFO_push_data), 32'(pmask[c]));
            check($sformatf("%s_ovf_c%0d", name, c), 32'(bus.overflow), 32'(omask[c]));
            @(posedge clk_pll);
            #1;
        end
        bus.data_valid = 1'b0;
        bus.FIFO_full  = 1'b0;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        repeat (2) @(posedge clk_pll);
        #1;
        reset_n = 1'b1;
        sb.delete();
    endtask

    int push_base;

    initial begin
        bus.data       = '0;
        bus.data_valid = 1'b0;
        bus.FIFO_full  = 1'b0;
        repeat (2) @(posedge clk_pll);
        #1;
        check("rst_push", 32'(bus.FIFO_push_data), 32'd0);
        check("rst_busy", 32'(bus.busy), 32'd0);
        check("rst_ovf", 32'(bus.overflow), 32'd0);
        check("rst_byte", 32'(bus.FIFO_input_data), 32'd0);
        reset_n = 1'b1;
        @(posedge clk_pll);
        #1;

        // Single word: pushes in cycles 2..5, idle from cycle 6.
        words.push_back(32'hAABB_CCDD);
        run_seq("single", 8, 32'h1, 32'h0, 32'h0, 32'h0000_003C, 32'h0);
        check("single_busy", 32'(bus.busy), 32'd0);
        check("single_drained", 32'(sb.size()), 32'd0);

        // Backpressure: FIFO_full in cycles 3..5 delays the remaining bytes to 6..8.
        push_base = n_push;
        words.push_back(32'hAABB_CCDD);
        run_seq("bp", 10, 32'h1, 32'h0, 32'h0000_0038, 32'h0000_01C4, 32'h0);
        check("bp_count", 32'(n_push - push_base), 32'd4);
        check("bp_busy", 32'(bus.busy), 32'd0);

        // Back-to-back: five words give 20 contiguous pushes in cycles 2..21.
        for (int i = 0; i < 5; i++) words.push_back($urandom);
        run_seq("b2b", 24, 32'h1F, 32'h0, 32'h0, 32'h003F_FFFC, 32'h0);
        check("b2b_drained", 32'(sb.size()), 32'd0);

        // Overflow: word 5 lands on a full-edge pop, word 6 is dropped.
        for (int i = 0; i < 7; i++) words.push_back($urandom);
        run_seq("ovf", 28, 32'h7F, 32'h40, 32'h0, 32'h03FF_FFFC, 32'hFFFF_FF80);
        check("ovf_drained", 32'(sb.size()), 32'd0);
        check("ovf_busy", 32'(bus.busy), 32'd0);
        repeat (3) @(posedge clk_pll);
        #1;
        check("ovf_sticky", 32'(bus.overflow), 32'd1);

        // Reset mid-word: assert reset in cycle 3 of a single-word transfer.
        do_reset();
        check("rst2_ovf", 32'(bus.overflow), 32'd0);
        words.push_back(32'hAABB_CCDD);
        run_seq("midrst", 3, 32'h1, 32'h0, 32'h0, 32'h0000_0004, 32'h0);
        reset_n = 1'b0;
        #1;
        check("midrst_push", 32'(bus.FIFO_push_data), 32'd0);
        check("midrst_busy", 32'(bus.busy), 32'd0);
        check("midrst_ovf", 32'(bus.overflow), 32'd0);
        sb.delete();
        @(posedge clk_pll);
        #1;
        reset_n = 1'b1;
        run_seq("postrst", 8, 32'h0, 32'h0, 32'h0, 32'h0, 32'h0);
        check("postrst_busy", 32'(bus.busy), 32'd0);
        check("postrst_sb", 32'(sb.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
